// File: rtl/imsic_msi_arbiter.sv
// imsic_msi_arbiter
//   Shares the IMSIC setipnum write port among NrReq MSI requesters. Each requester
//   pushes into its own FIFO. A round-robin arbiter pops at most one head per cycle,
//   and the head becomes a registered one-hot setipnum write strobe into the per-hart
//   interrupt files. MSIs with ipnum 0 or an out-of-range hart or file are
//   handshaken but never stored, and a saturating counter records them.
// Ports
//   i_clk, ni_rst                    clock, async active-low reset
//   i_req_valid / o_req_ready        per-requester handshake
//   i_req_hart/file/ipnum            per-requester MSI target and identity
//   o_setipnum, o_setipnum_we        per hart/file identity and write strobe (<=1 bit set)
//   o_drop_cnt                       saturating count of rejected MSIs
//   o_busy                           any FIFO non-empty or strobe in flight

// Per-requester FIFO. Ready and non-empty come from registered state only.
module imsic_msi_fifo #(
    parameter int DW    = 8,
    parameter int Depth = 4
) (
    input  logic          i_clk,
    input  logic          ni_rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          ready,
    output logic          nonempty
);
    localparam int AW = $clog2(Depth);

    logic [DW-1:0] mem [Depth];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because Depth is a power of two.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata    = mem[rd_ptr];
    assign ready    = (count != (AW+1)'(Depth));
    assign nonempty = (count != '0);
endmodule

module imsic_msi_arbiter #(
    parameter int NrReq       = 2,
    parameter int NrHarts     = 4,
    parameter int NrInptFiles = 3,
    parameter int NrSources   = 64,
    parameter int FifoDepth   = 4,
    localparam int HartW = (NrHarts > 1) ? $clog2(NrHarts) : 1,
    localparam int FileW = (NrInptFiles > 1) ? $clog2(NrInptFiles) : 1,
    localparam int SrcW  = $clog2(NrSources)
) (
    input  logic                                         i_clk,
    input  logic                                         ni_rst,
    input  logic [NrReq-1:0]                             i_req_valid,
    output logic [NrReq-1:0]                             o_req_ready,
    input  logic [NrReq-1:0][HartW-1:0]                  i_req_hart,
    input  logic [NrReq-1:0][FileW-1:0]                  i_req_file,
    input  logic [NrReq-1:0][SrcW-1:0]                   i_req_ipnum,
    output logic [NrHarts-1:0][NrInptFiles-1:0][SrcW-1:0] o_setipnum,
    output logic [NrHarts-1:0][NrInptFiles-1:0]          o_setipnum_we,
    output logic [15:0]                                  o_drop_cnt,
    output logic                                         o_busy
);
    localparam int PtrW = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam logic [HartW:0] HartLim = (HartW+1)'(NrHarts);
    localparam logic [FileW:0] FileLim = (FileW+1)'(NrInptFiles);

    typedef struct packed {
        logic [HartW-1:0] hart;
        logic [FileW-1:0] file;
        logic [SrcW-1:0]  ipnum;
    } msi_t;

    msi_t [NrReq-1:0] head;
    logic [NrReq-1:0] msi_ok, accept, push, pop, reject, nonempty;

    logic [PtrW-1:0]  rr_ptr, gnt_idx, cand;
    logic [PtrW:0]    idx;
    logic             grant;
    msi_t             gnt_msi;
    logic [16:0]      drop_sum;

    for (genvar r = 0; r < NrReq; r++) begin : g_req
        assign msi_ok[r] = (i_req_ipnum[r] != '0)
                         && ({1'b0, i_req_hart[r]} < HartLim)
                         && ({1'b0, i_req_file[r]} < FileLim);
        assign accept[r] = i_req_valid[r] & o_req_ready[r];
        assign push[r]   = accept[r] & msi_ok[r];
        assign reject[r] = accept[r] & ~msi_ok[r];
        assign pop[r]    = grant & (gnt_idx == PtrW'(r));

        imsic_msi_fifo #(.DW($bits(msi_t)), .Depth(FifoDepth)) u_fifo (
            .i_clk   (i_clk),
            .ni_rst  (ni_rst),
            .push    (push[r]),
            .pop     (pop[r]),
            .wdata   ({i_req_hart[r], i_req_file[r], i_req_ipnum[r]}),
            .rdata   (head[r]),
            .ready   (o_req_ready[r]),
            .nonempty(nonempty[r])
        );
    end

    // Round-robin search from rr_ptr, wrapping modulo NrReq; first non-empty FIFO wins.
    always_comb begin
        grant   = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        cand    = '0;
        for (int i = 0; i < NrReq; i++) begin
            idx = {1'b0, rr_ptr} + (PtrW+1)'(i);
            if (idx >= (PtrW+1)'(NrReq)) idx = idx - (PtrW+1)'(NrReq);
            cand = idx[PtrW-1:0];
            if (!grant && nonempty[cand]) begin
                grant   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_msi = head[gnt_idx];

    // Rejects from all requesters in one cycle are summed, then clamped.
    always_comb begin
        drop_sum = {1'b0, o_drop_cnt};
        for (int r = 0; r < NrReq; r++) drop_sum = drop_sum + 17'(reject[r]);
    end

    always_ff @(posedge i_clk or negedge ni_rst) begin
        if (!ni_rst) begin
            rr_ptr        <= '0;
            o_setipnum    <= '0;
            o_setipnum_we <= '0;
            o_drop_cnt    <= '0;
        end else begin
            o_drop_cnt    <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            o_setipnum    <= '0;
            o_setipnum_we <= '0;
            if (grant) begin
                rr_ptr <= (gnt_idx == PtrW'(NrReq - 1)) ? '0 : gnt_idx + 1'b1;
                o_setipnum_we[gnt_msi.hart][gnt_msi.file] <= 1'b1;
                o_setipnum[gnt_msi.hart][gnt_msi.file]    <= gnt_msi.ipnum;
            end
        end
    end

    assign o_busy = (|nonempty) | (|o_setipnum_we);
endmodule
